// File: rtl/polymul_sched.sv
// polymul_sched: round-robin scheduler that shares one polynomial multiplier
// among NREQ requesters.
// - The winner's operand degrees are captured at grant time.
// - The scheduler pulses mult_start and waits for mult_done.
// - The owner then gets a one-cycle req_done pulse.
// Optional feature: define POLYMUL_SCHED_TIMEOUT_EN to add a WAIT-state
// watchdog. It forces completion after TIMEOUT_CYC cycles and raises a sticky
// timeout_err output.
module polymul_sched #(
  parameter int NREQ        = 2,
  parameter int DEG_W       = 11,
  parameter int TIMEOUT_CYC = 1200000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DEG_W-1:0] req_dega,
  input  logic [NREQ*DEG_W-1:0] req_degb,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       req_done,
  output logic                  busy,
  output logic                  mult_start,
  output logic [DEG_W-1:0]      mult_dega,
  output logic [DEG_W-1:0]      mult_degb,
  input  logic                  mult_done
`ifdef POLYMUL_SCHED_TIMEOUT_EN
  ,
  output logic                  timeout_err
`endif
);

  localparam int OWN_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [OWN_W-1:0]   owner;       // index of the current grant holder
  logic [OWN_W-1:0]   last_owner;  // index of the previously served requester
  logic [OWN_W-1:0]   winner;
  logic               found;
  logic [NREQ-1:0]    sel_grant;
  logic [DEG_W-1:0]   sel_dega;
  logic [DEG_W-1:0]   sel_degb;
  int                 best_dist;
  logic               timeout_hit;

  // Round-robin search. The candidate at the smallest circular distance after
  // last_owner wins. The loop index stays constant per iteration, so every
  // slice select is static.
  // NOTE: every signal written here gets a default first. A path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    found     = 1'b0;
    winner    = '0;
    sel_grant = '0;
    sel_dega  = '0;
    sel_degb  = '0;
    best_dist = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && (((i + NREQ - 1 - int'(last_owner)) % NREQ) < best_dist)) begin
        best_dist    = (i + NREQ - 1 - int'(last_owner)) % NREQ;
        found        = 1'b1;
        winner       = OWN_W'(i);
        sel_grant    = '0;
        sel_grant[i] = 1'b1;
        sel_dega     = req_dega[i*DEG_W +: DEG_W];
        sel_degb     = req_degb[i*DEG_W +: DEG_W];
      end
    end
  end

`ifdef POLYMUL_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt;

  // The watchdog fires on the last cycle of the allowed window. It uses the
  // count of completed WAIT cycles.
  assign timeout_hit = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Count cycles spent in WAIT. The count restarts every time START hands over
  // to WAIT. timeout_err latches a forced completion until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == START) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (timeout_hit && !mult_done) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments. All
  // flops then see the same pre-edge values, whatever the order of processes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs. mult_done is honoured only in WAIT.
  always_comb begin
    state_nxt  = state;
    mult_start = 1'b0;
    req_done   = '0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = START;
        end
      end
      START: begin
        mult_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (mult_done || timeout_hit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        req_done  = grant;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant and degree snapshot at the IDLE->START edge. The grant is released
  // and the round-robin pointer is advanced when DONE exits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= '0;
      owner      <= '0;
      last_owner <= OWN_W'(NREQ - 1);
      mult_dega  <= '0;
      mult_degb  <= '0;
    end else begin
      if (state == IDLE && found) begin
        grant     <= sel_grant;
        owner     <= winner;
        mult_dega <= sel_dega;
        mult_degb <= sel_degb;
      end else if (state == DONE) begin
        grant      <= '0;
        last_owner <= owner;
      end
    end
  end

endmodule
